// File: rtl/fnd_scan_controller.sv
// Four-digit FND scan controller: sequential double-dabble conversion of a 14-bit value
// into BCD display registers, plus a free-running digit scanner driving the BCD-to-FND decoder.
module fnd_scan_controller #(
    parameter int P_SCAN_DIV = 100000
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [13:0] i_value,
    input  logic        i_load,
    input  logic        i_blank_lz,
    input  logic        i_En,
    output logic        o_ready,
    output logic        o_overflow,
    output logic [1:0]  o_DigitSelect,
    output logic [3:0]  o_value,
    output logic        o_En,
    output logic [1:0]  o_dbg_state
);

    localparam int PW = (P_SCAN_DIV > 2) ? $clog2(P_SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(P_SCAN_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_COMMIT  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          ready_q, ready_d;
    logic          overflow_q, overflow_d;
    logic          ovf_pend_q, ovf_pend_d;
    logic [13:0]   bin_q, bin_d;
    logic [15:0]   bcd_q, bcd_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [15:0]   disp_q, disp_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;

    logic [15:0]   bcd_adj;
    logic [3:0]    blank;

    // Add-3 correction applied to every nibble before the shift of each iteration.
    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < 4; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ready_d    = ready_q;
        overflow_d = overflow_q;
        ovf_pend_d = ovf_pend_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        disp_d     = disp_q;
        case (state_q)
            ST_IDLE: begin
                if (i_load) begin
                    bin_d      = (i_value > 14'd9999) ? 14'd9999 : i_value;
                    ovf_pend_d = (i_value > 14'd9999);
                    bcd_d      = '0;
                    cnt_d      = '0;
                    ready_d    = 1'b0;
                    state_d    = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                bcd_d = {bcd_adj[14:0], bin_q[13]};
                bin_d = {bin_q[12:0], 1'b0};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd13) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                disp_d     = bcd_q;
                overflow_d = ovf_pend_q;
                ready_d    = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Scanner free-runs regardless of the converter and of the enable input.
    always_comb begin
        presc_d = presc_q + PW'(1);
        idx_d   = idx_q;
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            idx_d   = idx_q + 2'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b1;
            overflow_q <= 1'b0;
            ovf_pend_q <= 1'b0;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            disp_q     <= '0;
            presc_q    <= '0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            overflow_q <= overflow_d;
            ovf_pend_q <= ovf_pend_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            disp_q     <= disp_d;
            presc_q    <= presc_d;
            idx_q      <= idx_d;
        end
    end

    // A digit is a leading zero when it and every more significant digit are zero.
    always_comb begin
        blank[0] = 1'b0;
        blank[1] = i_blank_lz && (disp_q[15:4] == 12'd0);
        blank[2] = i_blank_lz && (disp_q[15:8] == 8'd0);
        blank[3] = i_blank_lz && (disp_q[15:12] == 4'd0);
    end

    assign o_ready       = ready_q;
    assign o_overflow    = overflow_q;
    assign o_DigitSelect = idx_q;
    assign o_value       = disp_q[{idx_q, 2'b00} +: 4];
    assign o_En          = i_En & ~blank[idx_q];
    assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Bench for fnd_scan_controller: an integer-level display model predicts every output each
// cycle into a queue; an independent monitor pops and compares against the DUT.
`timescale 1ns/1ps
module tb_fnd_scan_controller;

    localparam int P = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] value = '0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic        en = 1'b1;

    logic        o_ready;
    logic        o_overflow;
    logic [1:0]  o_sel;
    logic [3:0]  o_val;
    logic        o_en;
    logic [1:0]  o_dbg_state;

    always #5 clk = ~clk;

    fnd_scan_controller #(.P_SCAN_DIV(P)) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_value       (value),
        .i_load        (load),
        .i_blank_lz    (blank_lz),
        .i_En          (en),
        .o_ready       (o_ready),
        .o_overflow    (o_overflow),
        .o_DigitSelect (o_sel),
        .o_value       (o_val),
        .o_En          (o_en),
        .o_dbg_state   (o_dbg_state)
    );

    // Reference model: displayed number as an integer, edges since reset, busy countdown.
    int m_cyc = 0;
    int m_busy = 0;
    int m_disp = 0;
    int m_pend = 0;
    bit m_ovf = 1'b0;
    bit m_pend_ovf = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc = 0;
            m_busy = 0;
            m_disp = 0;
            m_ovf = 1'b0;
        end else begin
            m_cyc = (m_cyc + 1) % (4 * P);
            if (m_busy > 0) begin
                m_busy = m_busy - 1;
                if (m_busy == 0) begin
                    m_disp = m_pend;
                    m_ovf = m_pend_ovf;
                end
            end else if (load) begin
                m_busy = 15;
                m_pend = (int'(value) > 9999) ? 9999 : int'(value);
                m_pend_ovf = (int'(value) > 9999);
            end
        end
    end

    function automatic logic [8:0] predict();
        int idx;
        int pw;
        int digit;
        bit blank;
        bit en_e;
        logic [1:0] sel;
        logic [3:0] dig4;
        idx = (m_cyc / P) % 4;
        pw = 1;
        for (int k = 0; k < idx; k++) pw = pw * 10;
        digit = (m_disp / pw) % 10;
        blank = (idx > 0) && blank_lz && (m_disp < pw);
        en_e = en && !blank;
        sel = idx[1:0];
        dig4 = digit[3:0];
        return {(m_busy == 0), m_ovf, sel, dig4, en_e};
    endfunction

    logic [8:0] exp_q[$];
    logic [8:0] exp_v;
    logic [8:0] act_v;
    int checks = 0;
    int errors = 0;
    bit done = 1'b0;

    always @(negedge clk) begin
        if (!done) exp_q.push_back(predict());
    end

    always @(negedge clk) begin
        if (!done) begin
            #1;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty t=%0t", $time);
            end else begin
                exp_v = exp_q.pop_front();
                act_v = {o_ready, o_overflow, o_sel, o_val, o_en};
                if (act_v !== exp_v) begin
                    errors++;
                    $display("FAIL scan_out t=%0t got rdy=%b ovf=%b sel=%0d val=%0d en=%b expected rdy=%b ovf=%b sel=%0d val=%0d en=%b",
                             $time, act_v[8], act_v[7], act_v[6:5], act_v[4:1], act_v[0],
                             exp_v[8], exp_v[7], exp_v[6:5], exp_v[4:1], exp_v[0]);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int v);
        int guard;
        guard = 0;
        while (m_busy != 0 && guard < 64) begin
            step(1);
            guard++;
        end
        if (guard >= 64) begin
            checks++;
            errors++;
            $display("FAIL load_wait_timeout got busy=%0d expected 0", m_busy);
        end
        value = v[13:0];
        load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    initial begin
        step(3);
        rst_n = 1'b1;
        step(6);
        rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(10);

        blank_lz = 1'b0;
        do_load(1234);
        step(32);

        blank_lz = 1'b1;
        do_load(7);
        step(20);
        blank_lz = 1'b0;
        step(16);
        blank_lz = 1'b1;
        do_load(0);
        step(20);

        do_load(12000);
        step(20);
        do_load(9999);
        step(20);

        do_load(1234);
        step(3);
        value = 14'd5678;
        load = 1'b1;
        step(1);
        load = 1'b0;
        step(16);
        do_load(5678);
        step(7);
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(8);

        blank_lz = 1'b0;
        do_load(1234);
        step(20);
        en = 1'b0;
        step(16);
        en = 1'b1;
        step(8);

        repeat (14) begin
            int v;
            v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10000, 16383))
                                            : int'($urandom_range(0, 9999));
            blank_lz = $urandom_range(0, 1);
            en = ($urandom_range(0, 3) != 0);
            do_load(v);
            step($urandom_range(2, 12));
            if ($urandom_range(0, 1) == 1) begin
                value = 14'($urandom_range(0, 16383));
                load = 1'b1;
                step(1);
                load = 1'b0;
            end
            step($urandom_range(14, 30));
            blank_lz = ~blank_lz;
            step($urandom_range(4, 16));
        end

        step(2);
        done = 1'b1;
        #20;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
